button_conditioner: RTL and testbench
=====================================

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 The block SHALL have parameter FILTER_LEN, default 4, giving the number of consecutive disagreeing synchronised samples needed to change an output.
REQ-002 The block SHALL have parameter STUCK_CYCLES, default 327680, giving the continuous-press duration that marks a button stuck (10 s at 32.768 kHz).
REQ-003 Port HCLK  input  1  system clock, 32.768 kHz nominal.
REQ-004 Port HRESETn  input  1  reset: asynchronous, active-low.
REQ-005 Port ModeRaw  input  1  raw Mode pin, asynchronous, low = pressed, may bounce.
REQ-006 Port TripRaw  input  1  raw Trip pin, asynchronous, low = pressed, may bounce.
REQ-007 Port Mode  output  1  conditioned Mode level, low = pressed, feeds button_manager Mode.
REQ-008 Port Trip  output  1  conditioned Trip level, low = pressed, feeds button_manager Trip.
REQ-009 Port ModeStuck  output  1  high while Mode is classified stuck.
REQ-010 Port TripStuck  output  1  high while Trip is classified stuck.

Function
REQ-011 Each raw input SHALL pass through a two-flop synchroniser clocked by HCLK before any other logic.
REQ-012 Each channel SHALL run an agreement counter of width clog2(FILTER_LEN+1): it clears on any cycle where the synchronised sample equals the current filtered level, and increments otherwise.
REQ-013 The filtered level SHALL toggle, and the counter clear, on the cycle the counter would reach FILTER_LEN.
REQ-014 Latency: a clean raw transition first sampled at edge k SHALL appear on the output at edge k+2+FILTER_LEN-1; an input glitch shorter than FILTER_LEN synchronised samples SHALL produce no output change.
REQ-015 Each channel SHALL run an FSM with states RELEASED, PRESSED, STUCK; reset state RELEASED.
REQ-016 RELEASED -> PRESSED when the filtered level goes low; PRESSED -> RELEASED when it goes high.
REQ-017 A saturating hold counter of width clog2(STUCK_CYCLES+1) SHALL clear on entry to PRESSED and increment each cycle in PRESSED; PRESSED -> STUCK when it reaches STUCK_CYCLES-1.
REQ-018 Outputs: Mode/Trip SHALL be low only in PRESSED, and high in RELEASED and STUCK (the stuck button is released to downstream); the Stuck flag SHALL be high only in STUCK.
REQ-019 STUCK -> RELEASED SHALL occur only when the filtered level goes high; no press event is generated on leaving STUCK.
REQ-020 The two channels SHALL be fully independent; simultaneous presses SHALL produce output edges on the same cycle.
REQ-021 All outputs SHALL be registered; no combinational path from a raw input to any output.

Reset
REQ-022 On HRESETn low, regardless of activity: synchroniser flops = 1, filtered levels = 1, all counters = 0, FSMs = RELEASED; Mode = Trip = 1, ModeStuck = TripStuck = 0.
REQ-023 A button held through reset release SHALL be reported pressed at edge 2+FILTER_LEN-1 after deassertion.

Configuration
REQ-024 Macro BUTTON_STUCK_DETECT_EN: when defined, the STUCK state, hold counter and Stuck flags SHALL be implemented as above.
REQ-025 When BUTTON_STUCK_DETECT_EN is undefined, the hold counter and STUCK state SHALL be absent, PRESSED SHALL persist indefinitely, and ModeStuck = TripStuck = 0 constantly.

Structure
REQ-026 Package button_pkg SHALL hold the channel state enum and the FILTER_LEN and STUCK_CYCLES default constants.
REQ-027 Sub-module button_channel (synchroniser, filter, FSM, hold counter) SHALL be instantiated twice, once for Mode and once for Trip.

Verification (FILTER_LEN=4, STUCK_CYCLES=64)
REQ-028 ModeRaw 1->0 clean at edge 10 -> Mode falls at edge 15; ModeRaw 0->1 at edge 40 -> Mode rises at edge 45.
REQ-029 TripRaw low pulse of 3 cycles, then 10 cycles of 1/0 bounce ending low -> Trip falls exactly 5 edges after the final stable low is first sampled; no earlier edge.
REQ-030 ModeRaw held low 200 cycles with macro defined -> Mode low 64 cycles then high, ModeStuck = 1 until release; release -> ModeStuck = 0, Mode stays high. Macro undefined -> Mode low throughout, ModeStuck = 0.
REQ-031 ModeRaw and TripRaw fall on the same edge -> Mode and Trip fall on the same edge 5 cycles later.
REQ-032 HRESETn pulsed low while Trip is pressed and ModeStuck = 1 -> all outputs return to reset values immediately; with TripRaw still low, Trip falls 5 edges after deassertion.

Source files
------------

// File: rtl/button_pkg.sv
// -----------------------------------------------------------------------------
// button_pkg
// Shared definitions for the button conditioner: the per-channel state enum
// and the default filter / stuck-detect constants.
// Build option: BUTTON_STUCK_DETECT_EN adds the STUCK state to the enum.
// -----------------------------------------------------------------------------
package button_pkg;

   // Consecutive disagreeing synchronised samples needed to flip a level
   localparam int FILTER_LEN_DEF   = 4;
   // Continuous press that marks a button stuck: 10 s at 32.768 kHz
   localparam int STUCK_CYCLES_DEF = 327680;

`ifdef BUTTON_STUCK_DETECT_EN
   typedef enum logic [1:0] {
      RELEASED = 2'd0,
      PRESSED  = 2'd1,
      STUCK    = 2'd2
   } btn_state_e;
`else
   typedef enum logic {
      RELEASED = 1'b0,
      PRESSED  = 1'b1
   } btn_state_e;
`endif

endpackage

// File: rtl/button_channel.sv
// -----------------------------------------------------------------------------
// button_channel
// One conditioned button: two-flop synchroniser, agreement-count debounce
// filter, and a RELEASED/PRESSED(/STUCK) state machine with registered outputs.
//
// Ports
//   HCLK     in   system clock
//   HRESETn  in   asynchronous active-low reset
//   raw      in   raw pin, asynchronous, low = pressed, may bounce
//   level    out  conditioned level, low only while PRESSED
//   stuck    out  high only while STUCK (constant 0 without the build option)
//
// Build option: BUTTON_STUCK_DETECT_EN enables the hold counter and STUCK.
// -----------------------------------------------------------------------------
module button_channel
   import button_pkg::*;
#(
   parameter int FILTER_LEN   = FILTER_LEN_DEF,
   parameter int STUCK_CYCLES = STUCK_CYCLES_DEF
) (
   input  logic HCLK,
   input  logic HRESETn,
   input  logic raw,
   output logic level,
   output logic stuck
);

   localparam int               CNT_W    = $clog2(FILTER_LEN + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

   if (FILTER_LEN < 1) begin : g_bad_filter_len
      $error("button_channel: FILTER_LEN must be at least 1");
   end
   if (STUCK_CYCLES < 2) begin : g_bad_stuck_cycles
      $error("button_channel: STUCK_CYCLES must be at least 2");
   end

   logic             sync1, sync2;
   logic             filt;
   logic [CNT_W-1:0] agree_cnt;
   logic             toggle;
   btn_state_e       state;

   // Synchroniser resets to the released level so a held button is seen
   // as a fresh press after reset.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         sync1 <= 1'b1;
         sync2 <= 1'b1;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
      end
   end

   // Flip on the cycle the count would reach FILTER_LEN. The FSM consumes
   // this same pulse so the output moves on the same edge as filt.
   assign toggle = (sync2 != filt) && (agree_cnt == CNT_LAST);

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         filt      <= 1'b1;
         agree_cnt <= '0;
      end else if (sync2 == filt) begin
         agree_cnt <= '0;
      end else if (toggle) begin
         filt      <= ~filt;
         agree_cnt <= '0;
      end else begin
         agree_cnt <= agree_cnt + 1'b1;
      end
   end

`ifdef BUTTON_STUCK_DETECT_EN
   localparam int                HOLD_W    = $clog2(STUCK_CYCLES + 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(STUCK_CYCLES - 1);

   logic [HOLD_W-1:0] hold_cnt;

   // RELEASED implies filt high and PRESSED/STUCK imply filt low, so a
   // toggle in RELEASED is a press and a toggle elsewhere is a release.
   // hold_cnt stops at HOLD_LAST, which is where PRESSED hands over to STUCK.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state    <= RELEASED;
         hold_cnt <= '0;
         level    <= 1'b1;
         stuck    <= 1'b0;
      end else begin
         case (state)
            RELEASED: if (toggle) begin
               state    <= PRESSED;
               hold_cnt <= '0;
               level    <= 1'b0;
            end
            PRESSED: begin
               if (toggle) begin
                  state <= RELEASED;
                  level <= 1'b1;
               end else if (hold_cnt == HOLD_LAST) begin
                  // Stuck button is shown released downstream
                  state <= STUCK;
                  level <= 1'b1;
                  stuck <= 1'b1;
               end else begin
                  hold_cnt <= hold_cnt + 1'b1;
               end
            end
            STUCK: if (toggle) begin
               // Leave quietly: level is already high, no press event
               state <= RELEASED;
               stuck <= 1'b0;
            end
            default: begin
               state <= RELEASED;
               level <= 1'b1;
               stuck <= 1'b0;
            end
         endcase
      end
   end
`else
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state <= RELEASED;
         level <= 1'b1;
      end else begin
         case (state)
            RELEASED: if (toggle) begin
               state <= PRESSED;
               level <= 1'b0;
            end
            PRESSED: if (toggle) begin
               state <= RELEASED;
               level <= 1'b1;
            end
         endcase
      end
   end

   assign stuck = 1'b0;
`endif

endmodule

// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
// Conditions the Mode and Trip push-buttons for button_manager: each pin is
// synchronised, debounced and optionally checked for a stuck press. The two
// channels are independent instances of button_channel.
//
// Ports
//   HCLK       in   system clock, 32.768 kHz nominal
//   HRESETn    in   asynchronous active-low reset
//   ModeRaw    in   raw Mode pin, low = pressed
//   TripRaw    in   raw Trip pin, low = pressed
//   Mode       out  conditioned Mode level, low = pressed
//   Trip       out  conditioned Trip level, low = pressed
//   ModeStuck  out  high while Mode is classified stuck
//   TripStuck  out  high while Trip is classified stuck
//
// Build option: BUTTON_STUCK_DETECT_EN enables stuck detection; without it
// ModeStuck and TripStuck are constant 0.
// -----------------------------------------------------------------------------
module button_conditioner
   import button_pkg::*;
#(
   parameter int FILTER_LEN   = FILTER_LEN_DEF,
   parameter int STUCK_CYCLES = STUCK_CYCLES_DEF
) (
   input  logic HCLK,
   input  logic HRESETn,
   input  logic ModeRaw,
   input  logic TripRaw,
   output logic Mode,
   output logic Trip,
   output logic ModeStuck,
   output logic TripStuck
);

   localparam int NUM_CH = 2;   // index 0 = Mode, 1 = Trip

   logic [NUM_CH-1:0] raw_vec;
   logic [NUM_CH-1:0] level_vec;
   logic [NUM_CH-1:0] stuck_vec;

   assign raw_vec = {TripRaw, ModeRaw};

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      button_channel #(
         .FILTER_LEN   (FILTER_LEN),
         .STUCK_CYCLES (STUCK_CYCLES)
      ) u_ch (
         .HCLK    (HCLK),
         .HRESETn (HRESETn),
         .raw     (raw_vec[g]),
         .level   (level_vec[g]),
         .stuck   (stuck_vec[g])
      );
   end

   // Straight from channel flops: no combinational path from any pin
   assign Mode      = level_vec[0];
   assign Trip      = level_vec[1];
   assign ModeStuck = stuck_vec[0];
   assign TripStuck = stuck_vec[1];

endmodule

// File: tb/tb_button_conditioner.sv
// -----------------------------------------------------------------------------
// tb_button_conditioner
// Scoreboard bench for button_conditioner (FILTER_LEN=4, STUCK_CYCLES=64).
// The driver issues one pin/reset setting per clock and pushes the outputs a
// reference model predicts for that edge; a monitor pops and compares after
// every edge. The model works on the pin history: a level flips when the
// last FILTER_LEN synchronised samples all differ from it, and a button low
// for STUCK_CYCLES edges counts as stuck (when BUTTON_STUCK_DETECT_EN is set).
// Directed sequences add edge-latency checks; a random phase follows.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_button_conditioner;

   localparam int F  = 4;
   localparam int S  = 64;
   localparam int HL = F + 2;   // pin history: sync delay plus filter window

   logic HCLK = 1'b0;
   logic HRESETn, ModeRaw, TripRaw;
   logic Mode, Trip, ModeStuck, TripStuck;

   button_conditioner #(.FILTER_LEN(F), .STUCK_CYCLES(S)) dut (
      .HCLK      (HCLK),
      .HRESETn   (HRESETn),
      .ModeRaw   (ModeRaw),
      .TripRaw   (TripRaw),
      .Mode      (Mode),
      .Trip      (Trip),
      .ModeStuck (ModeStuck),
      .TripStuck (TripStuck)
   );

   always #5 HCLK = ~HCLK;

   typedef struct {
      int   edge_n;
      logic mode, trip, ms, ts;
   } exp_t;

   exp_t q[$];
   exp_t mon_e;
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;

   // reference model state, per channel (0 = Mode, 1 = Trip)
   logic hist [2][HL];
   logic filt [2];
   int   low_since [2];

   always @(posedge HCLK) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // ---------------- monitor ----------------
   logic prev_mode = 1'b1, prev_trip = 1'b1;
   int   mode_fall = -1, mode_rise = -1, trip_fall = -1, trip_falls = 0;

   always @(posedge HCLK) begin
      #1;
      while (q.size() > 0 && q[0].edge_n <= cyc) begin
         mon_e = q.pop_front();
         chk($sformatf("outs{M,T,MS,TS}@edge%0d", mon_e.edge_n),
             {28'd0, Mode, Trip, ModeStuck, TripStuck},
             {28'd0, mon_e.mode, mon_e.trip, mon_e.ms, mon_e.ts});
      end
      if (prev_mode && !Mode) mode_fall = cyc;
      if (!prev_mode && Mode) mode_rise = cyc;
      if (prev_trip && !Trip) begin
         trip_fall = cyc;
         trip_falls++;
      end
      prev_mode = Mode;
      prev_trip = Trip;
   end

   // ---------------- driver + model ----------------
   task automatic model_reset();
      for (int c = 0; c < 2; c++) begin
         for (int i = 0; i < HL; i++) hist[c][i] = 1'b1;
         filt[c]      = 1'b1;
         low_since[c] = -1;
      end
   endtask

   // Drive one clock's worth of inputs (at posedge+3) and predict the
   // outputs after the next edge.
   task automatic step(input logic rst_n, input logic mr, input logic tr);
      logic [1:0] raw;
      logic       was_rst_n, all_diff, o, s;
      exp_t       e;
      was_rst_n = HRESETn;
      HRESETn   = rst_n;
      ModeRaw   = mr;
      TripRaw   = tr;
      if (was_rst_n === 1'b1 && rst_n === 1'b0) begin
         #1;
         chk("async_reset_outs", {28'd0, Mode, Trip, ModeStuck, TripStuck}, 32'hC);
      end
      raw      = {tr, mr};
      e.edge_n = cyc + 1;
      e.mode = 1'b1; e.trip = 1'b1; e.ms = 1'b0; e.ts = 1'b0;
      if (!rst_n) model_reset();
      for (int c = 0; c < 2; c++) begin
         if (rst_n) begin
            for (int i = 0; i < HL - 1; i++) hist[c][i] = hist[c][i+1];
            hist[c][HL-1] = raw[c];
            // hist[0..F-1] are the pin values sampled F+1..2 edges ago,
            // i.e. what the filter has seen up to this edge
            all_diff = 1'b1;
            for (int i = 0; i < F; i++) if (hist[c][i] == filt[c]) all_diff = 1'b0;
            if (all_diff) begin
               filt[c]      = ~filt[c];
               low_since[c] = filt[c] ? -1 : e.edge_n;
            end
         end
         if (filt[c]) begin
            o = 1'b1; s = 1'b0;
         end
`ifdef BUTTON_STUCK_DETECT_EN
         else if (e.edge_n - low_since[c] >= S) begin
            o = 1'b1; s = 1'b1;
         end
`endif
         else begin
            o = 1'b0; s = 1'b0;
         end
         if (c == 0) begin e.mode = o; e.ms = s; end
         else        begin e.trip = o; e.ts = s; end
      end
      q.push_back(e);
      @(posedge HCLK);
      #3;
   endtask

   initial begin
      int   t0, t1;
      int   run [2];
      logic lvl [2];
      logic rst_r;

      HRESETn = 1'b1;
      ModeRaw = 1'b1;
      TripRaw = 1'b1;
      model_reset();
      #1 HRESETn = 1'b0;
      #1 chk("reset_state", {28'd0, Mode, Trip, ModeStuck, TripStuck}, 32'hC);
      @(posedge HCLK);
      #3;
      repeat (3) step(1'b0, 1'b1, 1'b1);

      // clean press and release on Mode
      repeat (5) step(1'b1, 1'b1, 1'b1);
      t0 = cyc + 1;
      repeat (30) step(1'b1, 1'b0, 1'b1);
      t1 = cyc + 1;
      repeat (20) step(1'b1, 1'b1, 1'b1);
      chk("mode_fall_latency", mode_fall - t0, 5);
      chk("mode_rise_latency", mode_rise - t1, 5);

      // Trip: 3-cycle glitch, then 1/0 bounce ending low
      trip_falls = 0;
      repeat (3) step(1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 10; i++) begin
         if (i == 9) t0 = cyc + 1;
         step(1'b1, 1'b1, i[0] ? 1'b0 : 1'b1);
      end
      repeat (20) step(1'b1, 1'b1, 1'b0);
      chk("trip_bounce_latency", trip_fall - t0, 5);
      chk("trip_fall_count", trip_falls, 1);
      repeat (20) step(1'b1, 1'b1, 1'b1);

      // simultaneous press
      t0 = cyc + 1;
      repeat (20) step(1'b1, 1'b0, 1'b0);
      chk("simul_mode_fall", mode_fall - t0, 5);
      chk("simul_trip_fall", trip_fall - t0, 5);
      repeat (20) step(1'b1, 1'b1, 1'b1);

      // long Mode hold
      repeat (200) step(1'b1, 1'b0, 1'b1);
`ifdef BUTTON_STUCK_DETECT_EN
      chk("mode_low_cycles", mode_rise - mode_fall, S);
      chk("mode_stuck_flag", {31'd0, ModeStuck}, 1);
`else
      chk("mode_held_low", {31'd0, Mode}, 0);
`endif
      repeat (20) step(1'b1, 1'b1, 1'b1);

      // reset while Mode held long and Trip pressed; Trip pin stays low
      repeat (70) step(1'b1, 1'b0, 1'b1);
      repeat (10) step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b0);
      t0 = cyc + 1;   // first edge that samples the pin after release
      repeat (20) step(1'b1, 1'b1, 1'b0);
      chk("trip_after_reset_latency", trip_fall - t0, 5);
      repeat (20) step(1'b1, 1'b1, 1'b1);

      // random runs: mostly short (bounce), sometimes long (press / stuck)
      for (int c = 0; c < 2; c++) begin
         run[c] = 0;
         lvl[c] = 1'b1;
      end
      repeat (900) begin
         for (int c = 0; c < 2; c++) begin
            if (run[c] == 0) begin
               lvl[c] = ~lvl[c];
               run[c] = ($urandom_range(0, 9) == 0) ? int'($urandom_range(60, 100))
                                                    : int'($urandom_range(1, 7));
            end
            run[c]--;
         end
         rst_r = ($urandom_range(0, 399) != 0);
         step(rst_r, lvl[0], lvl[1]);
      end
      repeat (10) step(1'b1, 1'b1, 1'b1);

      @(posedge HCLK);
      #2;
      chk("scoreboard_drained", q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
